// File: rtl/mac_driver_if.sv
// Operand/product handshake between the batch driver and an external multiply unit.
interface mac_driver_if;
  logic [3:0] in1_IFM;
  logic [3:0] in2_IFM;
  logic       in_valid;
  logic [9:0] mac_out;
  logic       mac_out_valid;

  modport master (
    output in1_IFM, in2_IFM, in_valid,
    input  mac_out, mac_out_valid
  );

  modport slave (
    input  in1_IFM, in2_IFM, in_valid,
    output mac_out, mac_out_valid
  );
endinterface

// File: rtl/mac_driver.sv
// Queues operand pairs and drains them one at a time through an external MAC,
// accumulating the products of a batch and aborting if a result never arrives.
module mac_driver #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [3:0]   wr_in1,
  input  logic [3:0]   wr_in2,
  input  logic         start,
  output logic         full,
  output logic         empty,
  mac_driver_if.master mac,
  output logic [9:0]   res,
  output logic         res_valid,
  output logic [13:0]  acc,
  output logic         busy,
  output logic         done,
  output logic         timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e        state_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [TW-1:0] timer_q;
  logic [9:0]    res_q;
  logic          res_valid_q;
  logic [13:0]   acc_q;
  logic          done_q;
  logic          timeout_err_q;
  logic          push, pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = wr_en && !full;
  assign pop   = (state_q == ISSUE);

  always_comb begin
    // NOTE: default assignment first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + (AW+1)'(1);
    else if (pop && !push)
      count_d = count_q - (AW+1)'(1);
  end

  // NOTE: the storage array has no reset; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= {wr_in1, wr_in2};
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      timer_q       <= '0;
      res_q         <= '0;
      res_valid_q   <= 1'b0;
      acc_q         <= '0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q     <= count_d;
      res_valid_q <= 1'b0;
      done_q      <= (state_q == DONE);

      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q <= '0;
            if (!empty) begin
              timeout_err_q <= 1'b0;
              state_q       <= ISSUE;
            end else begin
              state_q <= DONE;
            end
          end
        end
        ISSUE: begin
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // Decision uses the pre-edge count: a pair pushed this very cycle is picked up next round.
          if (mac.mac_out_valid) begin
            res_q       <= mac.mac_out;
            res_valid_q <= 1'b1;
            acc_q       <= acc_q + {4'b0000, mac.mac_out};
            state_q     <= empty ? DONE : ISSUE;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            state_q       <= DONE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mac.in_valid = pop;
  assign mac.in1_IFM  = pop ? mem_q[rd_ptr_q][7:4] : 4'h0;
  assign mac.in2_IFM  = pop ? mem_q[rd_ptr_q][3:0] : 4'h0;

  assign res         = res_q;
  assign res_valid   = res_valid_q;
  assign acc         = acc_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mac_driver.sv
// Directed bench for mac_driver: a queue-based reference model checked every cycle,
// plus literal expectations for the batch scenarios.
module tb_mac_driver;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n, wr_en, start;
  logic [3:0]  wr_in1, wr_in2;
  logic        full, empty, res_valid, busy, done, timeout_err;
  logic [9:0]  res;
  logic [13:0] acc;

  always #5 clk = ~clk;

  mac_driver_if mif ();

  mac_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_in1(wr_in1), .wr_in2(wr_in2),
    .start(start), .full(full), .empty(empty), .mac(mif), .res(res),
    .res_valid(res_valid), .acc(acc), .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  // Reference model: pending pairs and the externally visible batch status.
  typedef struct { logic [3:0] a; logic [3:0] b; } pair_t;
  pair_t       mq[$];
  bit          m_active, m_issue, m_wait, m_done_pend, m_res_valid, m_done, m_terr;
  bit          was_full, nxt_issue;
  int          m_wcnt;
  logic [9:0]  m_res;
  logic [13:0] m_acc;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst_n === 1'b1) begin
      mq.delete();
      m_active = 0; m_issue = 0; m_wait = 0; m_done_pend = 0;
      m_res_valid = 0; m_done = 0; m_terr = 0; m_wcnt = 0;
      m_res = '0; m_acc = '0;
    end else begin
      was_full    = (mq.size() == DEPTH);
      nxt_issue   = 0;
      m_res_valid = 0;
      m_done      = 0;
      if (m_done_pend) begin
        m_done = 1; m_done_pend = 0; m_active = 0;
      end else if (!m_active) begin
        if (start) begin
          m_active = 1;
          m_acc    = '0;
          if (mq.size() != 0) begin m_terr = 0; nxt_issue = 1; end
          else m_done_pend = 1;
        end
      end else if (m_issue) begin
        void'(mq.pop_front());
        m_wait = 1; m_wcnt = 0;
      end else if (m_wait) begin
        if (mif.mac_out_valid) begin
          m_res = mif.mac_out;
          m_acc = m_acc + 14'(mif.mac_out);
          m_res_valid = 1; m_wait = 0;
          if (mq.size() != 0) nxt_issue = 1; else m_done_pend = 1;
        end else begin
          m_wcnt++;
          if (m_wcnt == TIMEOUT) begin m_terr = 1; m_wait = 0; m_done_pend = 1; end
        end
      end
      if (wr_en && !was_full) mq.push_back('{wr_in1, wr_in2});
      m_issue = nxt_issue;
    end
  end

  // MAC stand-in: answers an operand strobe four cycles later unless muted.
  typedef struct { int due; logic [9:0] p; } resp_t;
  resp_t pend[$];
  bit    mac_en = 1'b1;

  initial begin
    mif.mac_out = '0;
    mif.mac_out_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (mif.in_valid === 1'b1 && mac_en)
        pend.push_back('{cyc + 4, 10'(mif.in1_IFM) * 10'(mif.in2_IFM)});
      mif.mac_out_valid = 1'b0;
      mif.mac_out = '0;
      if (pend.size() != 0 && pend[0].due == cyc) begin
        mif.mac_out_valid = 1'b1;
        mif.mac_out = pend[0].p;
        void'(pend.pop_front());
      end
    end
  end

  int         n_checks = 0, n_errors = 0;
  bit         chk_en = 0;
  int         res_cyc[$], inv_cyc[$], done_cyc[$];
  logic [9:0] res_vals[$];
  int         terr_rise = -1;
  bit         terr_prev = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cyc_check();
    logic [3:0] ea, eb;
    if (!chk_en) return;
    ea = '0; eb = '0;
    if (m_issue && mq.size() != 0) begin ea = mq[0].a; eb = mq[0].b; end
    check("full", full, mq.size() == DEPTH);
    check("empty", empty, mq.size() == 0);
    check("busy", busy, m_active);
    check("in_valid", mif.in_valid, m_issue);
    check("in1_IFM", mif.in1_IFM, ea);
    check("in2_IFM", mif.in2_IFM, eb);
    check("res_valid", res_valid, m_res_valid);
    check("res", res, m_res);
    check("acc", acc, m_acc);
    check("done", done, m_done);
    check("timeout_err", timeout_err, m_terr);
    if (res_valid === 1'b1) begin res_cyc.push_back(cyc); res_vals.push_back(res); end
    if (mif.in_valid === 1'b1) inv_cyc.push_back(cyc);
    if (done === 1'b1) done_cyc.push_back(cyc);
    if (timeout_err === 1'b1 && !terr_prev) terr_rise = cyc;
    terr_prev = (timeout_err === 1'b1);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc_check();
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b);
    wr_en = 1'b1; wr_in1 = a; wr_in2 = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin tick(); n++; end
    check(name, done, 1'b1);
  endtask

  initial begin
    int rb, ib, db, s_cyc, n;
    rst_n = 1'b1; wr_en = 1'b0; start = 1'b0; wr_in1 = '0; wr_in2 = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    chk_en = 1'b1;
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_acc", acc, 0);
    check("rst_in_valid", mif.in_valid, 1'b0);
    tick();

    // Three-pair batch with a four-cycle MAC.
    rb = res_vals.size(); ib = inv_cyc.size(); db = done_cyc.size();
    push(4'd3, 4'd5); push(4'd15, 4'd15); push(4'd0, 4'd9);
    pulse_start();
    wait_done("b3_done", 40);
    check("b3_nres", res_vals.size() - rb, 3);
    if (res_vals.size() - rb == 3) begin
      check("b3_res0", res_vals[rb], 15);
      check("b3_res1", res_vals[rb+1], 225);
      check("b3_res2", res_vals[rb+2], 0);
      check("b3_done_gap", done_cyc[db] - res_cyc[rb+2], 1);
    end
    check("b3_acc", acc, 240);
    check("b3_ninv", inv_cyc.size() - ib, 3);
    if (inv_cyc.size() - ib == 3) begin
      check("b3_space0", inv_cyc[ib+1] - inv_cyc[ib], 5);
      check("b3_space1", inv_cyc[ib+2] - inv_cyc[ib+1], 5);
    end
    tick();

    // Start with nothing queued.
    ib = inv_cyc.size(); db = done_cyc.size();
    s_cyc = cyc;
    pulse_start();
    wait_done("empty_done", 10);
    check("empty_done_lat", done_cyc[db] - s_cyc, 2);
    check("empty_ninv", inv_cyc.size() - ib, 0);
    check("empty_acc", acc, 0);
    tick();

    // MAC never answers: abort after the wait budget, then a fresh start clears the flag.
    mac_en = 1'b0;
    ib = inv_cyc.size(); db = done_cyc.size();
    push(4'd2, 4'd2);
    pulse_start();
    wait_done("to_done", 40);
    check("to_err", timeout_err, 1'b1);
    check("to_acc", acc, 0);
    check("to_err_lat", terr_rise - inv_cyc[ib], 16);
    check("to_done_lat", done_cyc[db] - inv_cyc[ib], 17);
    tick();
    mac_en = 1'b1;
    push(4'd1, 4'd1);
    pulse_start();
    check("to_cleared", timeout_err, 1'b0);
    wait_done("to_rerun_done", 20);
    check("to_rerun_acc", acc, 1);
    tick();

    // Overfill: ninth push is dropped.
    rb = res_vals.size();
    for (int i = 0; i < 9; i++) begin
      push(4'(i + 1), 4'd15);
      if (i == 7) check("ovf_full8", full, 1'b1);
    end
    check("ovf_full9", full, 1'b1);
    pulse_start();
    wait_done("ovf_done", 80);
    check("ovf_nres", res_vals.size() - rb, 8);
    check("ovf_acc", acc, 540);
    check("ovf_empty", empty, 1'b1);
    tick();

    // Keep pushing while the batch drains; pushed pairs join the running batch.
    begin
      logic [3:0] ta [8] = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15};
      logic [3:0] tb [8] = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14, 4'd15};
      rb = res_vals.size();
      push(ta[0], tb[0]);
      push(ta[1], tb[1]);
      for (int i = 2; i < 8; i++) begin
        wr_en = 1'b1; wr_in1 = ta[i]; wr_in2 = tb[i];
        start = (i == 2);
        tick();
      end
      wr_en = 1'b0; start = 1'b0;
      wait_done("stream_done", 80);
      check("stream_nres", res_vals.size() - rb, 8);
      check("stream_acc", acc, 729);
      tick();
    end

    // Reset while waiting on the first result of a three-pair batch.
    rb = res_vals.size(); ib = inv_cyc.size(); db = done_cyc.size();
    push(4'd4, 4'd4); push(4'd5, 4'd5); push(4'd6, 4'd6);
    pulse_start();
    n = 0;
    while (mif.in_valid !== 1'b1 && n < 10) begin tick(); n++; end
    check("rst_mid_issue_seen", mif.in_valid, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_empty", empty, 1'b1);
    check("rst_mid_res", res, 0);
    check("rst_mid_acc", acc, 0);
    check("rst_mid_res_valid", res_valid, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    check("rst_mid_no_done", done_cyc.size() - db, 0);
    check("rst_mid_no_res", res_vals.size() - rb, 0);
    check("rst_mid_acc_late", acc, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mac_driver.md
MAC_DRIVER -- requirements
Module: mac_driver

Interface
REQ-001 Parameter: DEPTH, 8, operand-pair FIFO entries (power of 2).
REQ-002 Parameter: TIMEOUT, 15, maximum WAIT cycles allowed for a result before abort.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous reset, active-high (asserted = 1).
REQ-006 wr_en  input  1  push {wr_in1, wr_in2} into the FIFO.
REQ-007 wr_in1  input  4  operand A to queue.
REQ-008 wr_in2  input  4  operand B to queue.
REQ-009 start  input  1  begin draining the FIFO as one batch.
REQ-010 full  output  1  FIFO holds DEPTH entries.
REQ-011 empty  output  1  FIFO holds 0 entries.
REQ-012 in1_IFM  output  4  operand A to the MAC.
REQ-013 in2_IFM  output  4  operand B to the MAC.
REQ-014 in_valid  output  1  operand strobe to the MAC.
REQ-015 mac_out  input  10  MAC product.
REQ-016 mac_out_valid  input  1  MAC product strobe.
REQ-017 res  output  10  last captured product.
REQ-018 res_valid  output  1  one-cycle pulse: res updated.
REQ-019 acc  output  14  running batch sum of products.
REQ-020 busy  output  1  FSM not in IDLE.
REQ-021 done  output  1  one-cycle batch-complete pulse.
REQ-022 timeout_err  output  1  sticky: batch aborted on timeout.

Function
REQ-023 FSM states: IDLE, ISSUE, WAIT, DONE; all outputs driven from registers or decoded from registered state only.
REQ-024 IDLE: start && !empty -> ISSUE, acc cleared, timeout_err cleared; start && empty -> DONE, acc cleared; else stay.
REQ-025 ISSUE (exactly 1 cycle): in_valid=1, in1_IFM/in2_IFM = FIFO head, head popped at cycle end; -> WAIT, wait timer cleared.
REQ-026 in_valid, in1_IFM, in2_IFM SHALL be 0 in every state other than ISSUE.
REQ-027 WAIT: mac_out_valid=1 -> res<=mac_out, acc<=acc+mac_out, res_valid=1 next cycle; then -> ISSUE if FIFO non-empty, else -> DONE.
REQ-028 WAIT: timer increments each cycle without mac_out_valid; when timer reaches TIMEOUT -> timeout_err<=1, remaining FIFO entries retained, -> DONE.
REQ-029 DONE (exactly 1 cycle): done=1; -> IDLE.
REQ-030 Nominal latency: in_valid in cycle c -> mac_out_valid in c+4 -> res_valid and next in_valid in c+5; one product per 5 cycles.
REQ-031 acc arithmetic: unsigned, zero-extended 10-bit addend, wraps modulo 2^14, no saturation.
REQ-032 FIFO: write when full ignored (no state change); simultaneous push and pop when non-empty changes neither count nor full/empty; push during a batch joins that batch.
REQ-033 start while busy=1 ignored; mac_out_valid outside WAIT ignored.
REQ-034 busy=1 in ISSUE, WAIT, DONE.

Reset
REQ-035 rst_n=1 at a clock edge: FSM->IDLE, FIFO emptied (empty=1, full=0), timer=0, res=0, acc=0, in1_IFM=in2_IFM=0, in_valid=res_valid=done=timeout_err=busy=0; inputs ignored that cycle.
REQ-036 Reset mid-batch aborts without done pulse; first cycle after release is IDLE with empty FIFO.

Verification
REQ-037 Push (3,5),(15,15),(0,9); start; MAC model 4-cycle -> res_valid pulses with res=15,225,0; acc=240; done 1 cycle after last res_valid; in_valid spacing 5 cycles.
REQ-038 Push 9 pairs into DEPTH=8 -> full=1 after 8th, 9th dropped; batch yields exactly 8 res_valid pulses.
REQ-039 Push (2,2); start; MAC model never responds -> timeout_err=1 after 15 WAIT cycles, done pulse, acc=0; next start clears timeout_err.
REQ-040 start with empty FIFO -> no in_valid, done pulse 2 cycles later, acc=0.
REQ-041 Assert rst_n during WAIT of a 3-pair batch -> all outputs 0, empty=1, no done pulse; late mac_out_valid ignored.
REQ-042 Push every cycle while draining -> count stays consistent, no loss/duplication; acc equals sum of all pushed products mod 2^14.
